// File: rtl/rv32_pkg.sv
// Shared RV32I encoding definitions: instruction formats, base opcodes,
// the canonical NOP and the immediate range limits.
package rv32_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OPIMM  = 7'h13;
    localparam logic [6:0] OP_OP     = 7'h33;

    // addi x0,x0,0 -- substituted for any word that cannot be encoded
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;

    // Signed inclusive range test of a 32-bit immediate
    function automatic logic in_range(input logic [31:0] value, input int lo, input int hi);
        return ($signed(value) >= lo) && ($signed(value) <= hi);
    endfunction

endpackage

// File: rtl/imm_packer.sv
// Scatters the immediate into its format-specific bit positions of the
// instruction word and flags whether the immediate/format is encodable.
module imm_packer
    import rv32_pkg::*;
(
    input  logic [2:0]  format,
    input  logic [31:0] imm,
    output logic [31:0] imm_bits,
    output logic        legal
);

    // Per-format immediate placement and legality check
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch)
        imm_bits = '0;
        legal    = 1'b1;
        case (format)
            FMT_R: ;
            FMT_I: begin
                imm_bits[31:20] = imm[11:0];
                legal           = in_range(imm, IMM12_MIN, IMM12_MAX);
            end
            FMT_S: begin
                imm_bits[31:25] = imm[11:5];
                imm_bits[11:7]  = imm[4:0];
                legal           = in_range(imm, IMM12_MIN, IMM12_MAX);
            end
            FMT_B: begin
                imm_bits[31]    = imm[12];
                imm_bits[30:25] = imm[10:5];
                imm_bits[11:8]  = imm[4:1];
                imm_bits[7]     = imm[11];
                legal           = in_range(imm, IMM_B_MIN, IMM_B_MAX) && !imm[0];
            end
            FMT_U: begin
                imm_bits[31:12] = imm[31:12];
                legal           = (imm[11:0] == 12'd0);
            end
            FMT_J: begin
                imm_bits[31]    = imm[20];
                imm_bits[30:21] = imm[10:1];
                imm_bits[20]    = imm[11];
                imm_bits[19:12] = imm[19:12];
                legal           = in_range(imm, IMM_J_MIN, IMM_J_MAX) && !imm[0];
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word and
// holds it, with its byte address, in a one-entry output register.
module instruction_encoder
    import rv32_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        format,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        func3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        func7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] addr,
    output logic              err,
    output logic [7:0]        err_count
);

    logic [31:0]       imm_bits;
    logic              legal;
    logic [31:0]       reg_bits;
    logic [31:0]       word;
    logic              in_fire;
    logic              out_fire;
    logic [ADDR_W-1:0] next_addr;

    imm_packer u_imm_packer (
        .format   (format),
        .imm      (imm),
        .imm_bits (imm_bits),
        .legal    (legal)
    );

    assign in_ready = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Register-field placement per format, merged with the immediate bits
    always_comb begin
        reg_bits = {25'd0, opcode};
        case (format)
            FMT_R:        reg_bits = {func7, rs2, rs1, func3, rd, opcode};
            FMT_I:        reg_bits = {12'd0, rs1, func3, rd, opcode};
            FMT_S, FMT_B: reg_bits = {7'd0, rs2, rs1, func3, 5'd0, opcode};
            FMT_U, FMT_J: reg_bits = {20'd0, rd, opcode};
            default:      reg_bits = {25'd0, opcode};
        endcase
        word = legal ? (reg_bits | imm_bits) : NOP_WORD;
    end

    // Output register, address counter and saturating error counter
    // next_addr is the address the next accepted word will carry, so a word
    // accepted in the same edge its predecessor leaves gets old addr + 4.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all state here is control/handshake state, so every flop is reset
        if (!rst_n) begin
            out_valid   <= 1'b0;
            instruction <= '0;
            addr        <= BASE_ADDR;
            next_addr   <= BASE_ADDR;
            err         <= 1'b0;
            err_count   <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            addr      <= BASE_ADDR;
            next_addr <= BASE_ADDR;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values
            if (out_fire && err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (in_fire) begin
                out_valid   <= 1'b1;
                instruction <= word;
                err         <= !legal;
                addr        <= next_addr;
                next_addr   <= next_addr + ADDR_W'(4);
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
